// File: rtl/control_unit.sv
// Front-panel mode/routing controller: merges physical switches/buttons with
// UART-decoder virtual pulses into watch mode, display select and sensor triggers.
module control_unit (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iSw0,
    input  logic       iSw1,
    input  logic       iSw2,
    input  logic       iSw3,
    input  logic       iPhysBtnC,
    input  logic       iPhysBtnU,
    input  logic       iPhysBtnD,
    input  logic       iPhysBtnL,
    input  logic       iPhysBtnR,
    input  logic       iDecBtnC,
    input  logic       iDecBtnU,
    input  logic       iDecBtnD,
    input  logic       iDecBtnL,
    input  logic       iDecBtnR,
    input  logic       iDecTglSw0,
    input  logic       iDecTglSw1,
    input  logic       iDecTglSw2,
    input  logic       iDecTglSw3,
    input  logic       iDecClrSwTgl,
    input  logic       iDecReqWatchRpt,
    input  logic       iDecReqSr04Rpt,
    input  logic       iDecReqTempRpt,
    input  logic       iDecReqHumRpt,
    output logic       oWatchMode,
    output logic       oWatchDisplay,
    output logic [1:0] oDisplaySelect,
    output logic       oBtnC,
    output logic       oBtnU,
    output logic       oBtnD,
    output logic       oBtnL,
    output logic       oBtnR,
    output logic       oReqWatchRpt,
    output logic       oReqSr04Rpt,
    output logic       oReqTempRpt,
    output logic       oReqHumRpt,
    output logic       oSr04Start,
    output logic       oDht11Start
);

    localparam int unsigned NUM_SW = 4;

    localparam logic [1:0] SEL_WATCH = 2'b00;
    localparam logic [1:0] SEL_SR04  = 2'b01;
    localparam logic [1:0] SEL_DHT11 = 2'b10;

    logic [NUM_SW-1:0] r_tgl;
    logic [NUM_SW-1:0] w_tgl_pulse;
    logic [NUM_SW-1:0] w_phys_sw;
    logic [NUM_SW-1:0] w_eff_sw;
    logic [1:0]        w_sel;

    assign w_tgl_pulse = {iDecTglSw3, iDecTglSw2, iDecTglSw1, iDecTglSw0};
    assign w_phys_sw   = {iSw3, iSw2, iSw1, iSw0};

    // Toggle overrides; clear takes priority over any same-cycle toggle pulse
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_tgl <= '0;
        end else if (iDecClrSwTgl) begin
            r_tgl <= '0;
        end else begin
            r_tgl <= r_tgl ^ w_tgl_pulse;
        end
    end

    assign w_eff_sw = w_phys_sw ^ r_tgl;

    always_comb begin
        w_sel = SEL_WATCH;
        if (w_eff_sw[2]) begin
            w_sel = w_eff_sw[3] ? SEL_DHT11 : SEL_SR04;
        end
    end

    assign oWatchMode     = w_eff_sw[0];
    assign oWatchDisplay  = w_eff_sw[1];
    assign oDisplaySelect = w_sel;

    assign oBtnC = iPhysBtnC | iDecBtnC;
    assign oBtnU = iPhysBtnU | iDecBtnU;
    assign oBtnD = iPhysBtnD | iDecBtnD;
    assign oBtnL = iPhysBtnL | iDecBtnL;
    assign oBtnR = iPhysBtnR | iDecBtnR;

    assign oReqWatchRpt = iDecReqWatchRpt;
    assign oReqSr04Rpt  = iDecReqSr04Rpt;
    assign oReqTempRpt  = iDecReqTempRpt;
    assign oReqHumRpt   = iDecReqHumRpt;

    // Centre button starts whichever sensor is currently on the display
    assign oSr04Start  = oBtnC & (w_sel == SEL_SR04);
    assign oDht11Start = oBtnC & (w_sel == SEL_DHT11);

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit against a behavioural model
// of the toggle overrides and output routing.
module tb_control_unit;

    logic       iClk;
    logic       iRst;
    logic [3:0] sw;
    logic [4:0] pbtn;   // {C,U,D,L,R}
    logic [4:0] dbtn;   // {C,U,D,L,R}
    logic [3:0] dtgl;
    logic       dclr;
    logic [3:0] dreq;   // {Hum,Temp,Sr04,Watch}

    logic       oWatchMode, oWatchDisplay;
    logic [1:0] oDisplaySelect;
    logic       oBtnC, oBtnU, oBtnD, oBtnL, oBtnR;
    logic       oReqWatchRpt, oReqSr04Rpt, oReqTempRpt, oReqHumRpt;
    logic       oSr04Start, oDht11Start;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [3:0]  m_tgl;

    control_unit dut (
        .iClk(iClk), .iRst(iRst),
        .iSw0(sw[0]), .iSw1(sw[1]), .iSw2(sw[2]), .iSw3(sw[3]),
        .iPhysBtnC(pbtn[4]), .iPhysBtnU(pbtn[3]), .iPhysBtnD(pbtn[2]),
        .iPhysBtnL(pbtn[1]), .iPhysBtnR(pbtn[0]),
        .iDecBtnC(dbtn[4]), .iDecBtnU(dbtn[3]), .iDecBtnD(dbtn[2]),
        .iDecBtnL(dbtn[1]), .iDecBtnR(dbtn[0]),
        .iDecTglSw0(dtgl[0]), .iDecTglSw1(dtgl[1]),
        .iDecTglSw2(dtgl[2]), .iDecTglSw3(dtgl[3]),
        .iDecClrSwTgl(dclr),
        .iDecReqWatchRpt(dreq[0]), .iDecReqSr04Rpt(dreq[1]),
        .iDecReqTempRpt(dreq[2]), .iDecReqHumRpt(dreq[3]),
        .oWatchMode(oWatchMode), .oWatchDisplay(oWatchDisplay),
        .oDisplaySelect(oDisplaySelect),
        .oBtnC(oBtnC), .oBtnU(oBtnU), .oBtnD(oBtnD), .oBtnL(oBtnL), .oBtnR(oBtnR),
        .oReqWatchRpt(oReqWatchRpt), .oReqSr04Rpt(oReqSr04Rpt),
        .oReqTempRpt(oReqTempRpt), .oReqHumRpt(oReqHumRpt),
        .oSr04Start(oSr04Start), .oDht11Start(oDht11Start)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model's view of the current inputs
    task automatic check_all(input string tag);
        logic [3:0] eff;
        int         sel;
        logic [4:0] btn;
        eff = sw ^ m_tgl;
        if (eff[2] == 1'b0)      sel = 0;
        else if (eff[3] == 1'b0) sel = 1;
        else                     sel = 2;
        btn = pbtn | dbtn;
        check({tag, ".mode"}, 32'(oWatchMode), 32'(eff[0]));
        check({tag, ".disp"}, 32'(oWatchDisplay), 32'(eff[1]));
        check({tag, ".sel"}, 32'(oDisplaySelect), 32'(sel));
        check({tag, ".btn"}, 32'({oBtnC, oBtnU, oBtnD, oBtnL, oBtnR}), 32'(btn));
        check({tag, ".req"}, 32'({oReqHumRpt, oReqTempRpt, oReqSr04Rpt, oReqWatchRpt}), 32'(dreq));
        check({tag, ".sr04"}, 32'(oSr04Start), 32'(btn[4] && sel == 1));
        check({tag, ".dht"}, 32'(oDht11Start), 32'(btn[4] && sel == 2));
    endtask

    // Advance one clock edge, updating the model with the inputs held across it
    task automatic tick();
        @(posedge iClk);
        if (!iRst)     m_tgl = 4'h0;
        else if (dclr) m_tgl = 4'h0;
        else           m_tgl = m_tgl ^ dtgl;
        #1;
    endtask

    task automatic pulse_tgl(input int n);
        dtgl[n] = 1'b1;
        tick();
        dtgl = 4'h0;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_tgl    = 4'h0;
        iRst = 1'b0;
        sw   = 4'b0110;
        pbtn = '0; dbtn = '0; dtgl = '0; dclr = 1'b0; dreq = '0;
        #2;
        check_all("reset");
        check("reset_sel01", 32'(oDisplaySelect), 32'd1);

        @(posedge iClk); #1;
        iRst = 1'b1;
        #1;
        check_all("post_reset");

        pulse_tgl(0);
        check("tgl0_mode", 32'(oWatchMode), 32'd1);
        check_all("tgl0");
        pulse_tgl(1);
        check("tgl1_disp", 32'(oWatchDisplay), 32'd0);
        pulse_tgl(2);
        check("tgl2_sel00", 32'(oDisplaySelect), 32'd0);
        pulse_tgl(2);
        check("tgl2b_sel01", 32'(oDisplaySelect), 32'd1);
        check_all("tgl2b");

        dbtn[3] = 1'b1; #1;
        check("decU", 32'(oBtnU), 32'd1);
        dbtn = '0; pbtn[4] = 1'b1; #1;
        check("physC", 32'(oBtnC), 32'd1);
        check_all("physC");
        pbtn = '0;

        dbtn[4] = 1'b1; #1;
        check("sr04_trig", 32'({oSr04Start, oDht11Start}), 32'b10);
        dbtn = '0;
        pulse_tgl(3);
        dbtn[4] = 1'b1; #1;
        check("dht_trig", 32'({oSr04Start, oDht11Start}), 32'b01);
        check_all("dht_trig");
        dbtn = '0;
        pulse_tgl(2);
        dbtn[4] = 1'b1; pbtn[4] = 1'b1; #1;
        check("watch_trig", 32'({oSr04Start, oDht11Start}), 32'b00);
        dbtn = '0; pbtn = '0;

        dreq = 4'hF; #1;
        check("req_hi", 32'({oReqHumRpt, oReqTempRpt, oReqSr04Rpt, oReqWatchRpt}), 32'hF);
        dreq = 4'h0; #1;
        check("req_lo", 32'({oReqHumRpt, oReqTempRpt, oReqSr04Rpt, oReqWatchRpt}), 32'h0);

        dclr = 1'b1; tick(); dclr = 1'b0; #1;
        check("clr_out", 32'({oWatchMode, oWatchDisplay, oDisplaySelect}), 32'b0101);
        dclr = 1'b1; dtgl[0] = 1'b1; tick(); dclr = 1'b0; dtgl = '0; #1;
        check("clr_prio", 32'(oWatchMode), 32'd0);

        pulse_tgl(0); pulse_tgl(3);
        iRst = 1'b0; #1;
        m_tgl = 4'h0;
        check("async_rst", 32'({oWatchMode, oWatchDisplay, oDisplaySelect}), 32'b0101);
        check_all("async_rst");
        @(posedge iClk); #1;
        iRst = 1'b1; #1;

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) sw = 4'($urandom);
            pbtn = 5'($urandom) & 5'($urandom);
            dbtn = 5'($urandom) & 5'($urandom);
            dtgl = 4'($urandom) & 4'($urandom);
            dclr = ($urandom_range(0, 9) == 0);
            dreq = 4'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                iRst = 1'b0; #1;
                m_tgl = 4'h0;
            end else begin
                iRst = 1'b1; #1;
            end
            check_all("rand");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
